// File: rtl/sar_conv_ctrl_pkg.sv
// Shared constants for the SAR ADC sequencer and the SPI register block.
// Holds the control-register bit/field positions and the sequencer state encoding.
package sar_conv_ctrl_pkg;

  localparam int CTRL_W     = 12;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_CONT  = 2;
  localparam int SAMP_LSB   = 4;   // sample_len  = ctrl[7:4]
  localparam int SETTLE_LSB = 8;   // settle_len  = ctrl[11:8]
  localparam int FIELD_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sar_conv_ctrl_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit (the comparator output).
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset, clears the chain
//   d_i    - asynchronous input
//   q_o    - synchronized output, STAGES clocks of latency (STAGES >= 2)
module sar_conv_ctrl_bit_sync
  import sar_conv_ctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sar_conv_ctrl.sv
// Sequencer for the SAR ADC: sample phase, N_BITS binary-search bit trials on the DAC
// and comparator, result capture and EOC pulse generation.
// Ports:
//   clk_i            - system clock
//   reset_i          - asynchronous active-high reset; all outputs 0 while asserted
//   ctrl_reg_i       - [0]=enable [1]=start [2]=continuous [7:4]=sample_len [11:8]=settle_len
//   cmp_i            - asynchronous comparator, 1 = Vin >= Vdac
//   dac_code_o       - DAC drive code
//   sample_en_o      - track/hold switch closed while 1
//   adc_busy_o       - 1 whenever the sequencer is not idle
//   adc_eoc_pulse_o  - EOC_CYCLES-wide pulse per completed conversion
//   adc_data_o       - last completed result
//   hw_clear_start_o - 1-cycle strobe asking the register block to clear the start bit
//
// state      | meaning
// IDLE       | waiting for enable & start, DAC parked at 0
// SAMPLE     | track/hold closed for sample_len+1 cycles
// CONVERT    | bit trials MSB..LSB, settle_len+SYNC_STAGES+1 cycles each
// DONE       | publish result, fire EOC, loop back if continuous
module sar_conv_ctrl
  import sar_conv_ctrl_pkg::*;
#(
  parameter int N_BITS      = 12,
  parameter int SYNC_STAGES = 2,
  parameter int EOC_CYCLES  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [CTRL_W-1:0] ctrl_reg_i,
  input  logic              cmp_i,
  output logic [N_BITS-1:0] dac_code_o,
  output logic              sample_en_o,
  output logic              adc_busy_o,
  output logic              adc_eoc_pulse_o,
  output logic [N_BITS-1:0] adc_data_o,
  output logic              hw_clear_start_o
);

  localparam int IDX_W = $clog2(N_BITS);
  localparam int CNT_W = $clog2((1 << FIELD_W) + SYNC_STAGES);
  localparam int EOC_W = $clog2(EOC_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [N_BITS-1:0]  acc_q, acc_d;
  logic [N_BITS-1:0]  dac_code_q, dac_code_d;
  logic [N_BITS-1:0]  adc_data_q, adc_data_d;
  logic [EOC_W-1:0]   eoc_cnt_q, eoc_cnt_d;
  logic               snap_cont_q, snap_cont_d;
  logic [FIELD_W-1:0] snap_samp_q, snap_samp_d;
  logic [FIELD_W-1:0] snap_settle_q, snap_settle_d;
  logic               clr_start_q, clr_start_d;
  logic               cmp_sync;
  logic [N_BITS-1:0]  resolved;
  logic [CNT_W-1:0]   t_bit_m1;
  logic               unused_ctrl;

  assign unused_ctrl = ctrl_reg_i[3];

  sar_conv_ctrl_bit_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (cmp_i),
    .q_o   (cmp_sync)
  );

  // Trial length minus one: the comparator needs settle_len cycles plus the synchronizer
  // latency before the last cycle of the trial sees a valid decision.
  assign t_bit_m1 = CNT_W'(snap_settle_q) + CNT_W'(SYNC_STAGES);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    acc_d         = acc_q;
    dac_code_d    = dac_code_q;
    adc_data_d    = adc_data_q;
    eoc_cnt_d     = (eoc_cnt_q != '0) ? eoc_cnt_q - EOC_W'(1) : eoc_cnt_q;
    snap_cont_d   = snap_cont_q;
    snap_samp_d   = snap_samp_q;
    snap_settle_d = snap_settle_q;
    clr_start_d   = 1'b0;
    // Trial bit survives only if the comparator says Vin >= Vdac.
    resolved      = cmp_sync ? dac_code_q : acc_q;

    if (state_q != ST_IDLE && !ctrl_reg_i[CTRL_EN]) begin
      // Abort: drop the conversion, no EOC, previous result stays visible.
      state_d    = ST_IDLE;
      dac_code_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_reg_i[CTRL_EN] && ctrl_reg_i[CTRL_START]) begin
            state_d       = ST_SAMPLE;
            clr_start_d   = 1'b1;
            snap_cont_d   = ctrl_reg_i[CTRL_CONT];
            snap_samp_d   = ctrl_reg_i[SAMP_LSB +: FIELD_W];
            snap_settle_d = ctrl_reg_i[SETTLE_LSB +: FIELD_W];
            cnt_d         = CNT_W'(ctrl_reg_i[SAMP_LSB +: FIELD_W]);
          end
        end
        ST_SAMPLE: begin
          if (cnt_q == '0) begin
            state_d    = ST_CONVERT;
            bit_idx_d  = IDX_W'(N_BITS - 1);
            acc_d      = '0;
            dac_code_d = N_BITS'(1) << (N_BITS - 1);
            cnt_d      = t_bit_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          if (cnt_q == '0) begin
            acc_d = resolved;
            if (bit_idx_q == '0) begin
              state_d    = ST_DONE;
              dac_code_d = '0;
            end else begin
              bit_idx_d  = bit_idx_q - IDX_W'(1);
              dac_code_d = resolved | (N_BITS'(1) << (bit_idx_q - IDX_W'(1)));
              cnt_d      = t_bit_m1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          adc_data_d  = acc_q;
          eoc_cnt_d   = EOC_W'(EOC_CYCLES);   // reload stretches an overlapping pulse
          // Mode was fixed at start; the live bit is re-read so clearing it ends the run
          // after this lap. Timing fields keep their start-time snapshot.
          snap_cont_d = ctrl_reg_i[CTRL_CONT];
          if (snap_cont_q && ctrl_reg_i[CTRL_CONT]) begin
            state_d = ST_SAMPLE;
            cnt_d   = CNT_W'(snap_samp_q);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      acc_q         <= '0;
      dac_code_q    <= '0;
      adc_data_q    <= '0;
      eoc_cnt_q     <= '0;
      snap_cont_q   <= 1'b0;
      snap_samp_q   <= '0;
      snap_settle_q <= '0;
      clr_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      acc_q         <= acc_d;
      dac_code_q    <= dac_code_d;
      adc_data_q    <= adc_data_d;
      eoc_cnt_q     <= eoc_cnt_d;
      snap_cont_q   <= snap_cont_d;
      snap_samp_q   <= snap_samp_d;
      snap_settle_q <= snap_settle_d;
      clr_start_q   <= clr_start_d;
    end
  end

  assign dac_code_o       = dac_code_q;
  assign sample_en_o      = (state_q == ST_SAMPLE);
  assign adc_busy_o       = (state_q != ST_IDLE);
  assign adc_eoc_pulse_o  = (eoc_cnt_q != '0);
  assign adc_data_o       = adc_data_q;
  assign hw_clear_start_o = clr_start_q;

endmodule

// File: tb/tb_sar_conv_ctrl.sv
module tb_sar_conv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] ctrl = '0;
  logic [11:0] vin = '0;
  logic        cmp;
  logic [11:0] dac_code, adc_data;
  logic        sample_en, busy, eoc, hw_clear;

  always #5 clk = ~clk;

  // Comparator model: 1 when Vin >= Vdac.
  assign cmp = (dac_code <= vin);

  sar_conv_ctrl #(.N_BITS(12), .SYNC_STAGES(2), .EOC_CYCLES(2)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .ctrl_reg_i       (ctrl),
    .cmp_i            (cmp),
    .dac_code_o       (dac_code),
    .sample_en_o      (sample_en),
    .adc_busy_o       (busy),
    .adc_eoc_pulse_o  (eoc),
    .adc_data_o       (adc_data),
    .hw_clear_start_o (hw_clear)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observation records, sampled on the falling edge.
  int          busy_run, samp_run, clr_n, eoc_hi;
  bit          eoc_d, in_run;
  int          busy_spans[$], samp_spans[$], len_q[$];
  logic [11:0] code_q[$], data_q[$];

  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin busy_spans.push_back(busy_run); busy_run = 0; end
    if (sample_en) samp_run++;
    else if (samp_run != 0) begin samp_spans.push_back(samp_run); samp_run = 0; end
    if (hw_clear) clr_n++;
    if (eoc) eoc_hi++;
    if (eoc && !eoc_d) data_q.push_back(adc_data);
    eoc_d = eoc;
    if (busy && !sample_en && dac_code != 0) begin
      if (in_run && dac_code == code_q[$]) len_q[len_q.size()-1] = len_q[len_q.size()-1] + 1;
      else begin code_q.push_back(dac_code); len_q.push_back(1); end
      in_run = 1;
    end else in_run = 0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #2; end
  endtask

  task automatic mon_clear();
    busy_run = 0; samp_run = 0; clr_n = 0; eoc_hi = 0; in_run = 0;
    busy_spans.delete(); samp_spans.delete(); len_q.delete(); code_q.delete(); data_q.delete();
  endtask

  // Writes ctrl, waits for the clear strobe and clears the start bit like the register block.
  task automatic start_conv(input logic [11:0] c);
    bit seen = 0;
    ctrl = c;
    for (int k = 0; k < 4 && !seen; k++) begin step(1); if (hw_clear) seen = 1; end
    ctrl[1] = 1'b0;
    n_checks++;
    if (!seen) $display("FAIL start_strobe: hw_clear_start never seen for ctrl %h", c);
    else n_pass++;
  endtask

  task automatic wait_spans(input int n, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (busy_spans.size() >= n) begin ok = 1; break; end
      step(1);
    end
  endtask

  // Textbook successive approximation: code presented at trial i.
  function automatic logic [11:0] trial_code(input logic [11:0] v, input int i);
    logic [11:0] acc = '0;
    logic [11:0] bitv;
    for (int b = 11; b > i; b--) begin
      bitv = 12'(1) << b;
      if ((acc | bitv) <= v) acc = acc | bitv;
    end
    return acc | (12'(1) << i);
  endfunction

  task automatic test_reset();
    rst = 1; ctrl = 12'h003; vin = 12'h5A5;
    step(3);
    n_checks++;
    if ({dac_code, adc_data, sample_en, busy, eoc, hw_clear} !== '0)
      $display("FAIL reset_outputs: got dac=%h data=%h se=%b busy=%b eoc=%b clr=%b want all 0",
               dac_code, adc_data, sample_en, busy, eoc, hw_clear);
    else n_pass++;
    ctrl = 12'h000; rst = 0;
    step(3);
    n_checks++;
    if ({busy, hw_clear, eoc} !== 3'b000)
      $display("FAIL idle_no_start: got busy=%b clr=%b eoc=%b want 000", busy, hw_clear, eoc);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit ok; int bad = 0;
    mon_clear(); vin = 12'hA5C;
    start_conv(12'h003);
    wait_spans(1, 200, ok);
    step(3);
    n_checks++; if (!ok) $display("FAIL basic_timeout: busy never dropped"); else n_pass++;
    n_checks++; if (clr_n !== 1) $display("FAIL basic_clr_cycles: got %0d want 1", clr_n); else n_pass++;
    n_checks++;
    if (samp_spans.size() !== 1 || samp_spans[0] !== 1)
      $display("FAIL basic_sample_len: got %0d spans first %0d want 1 span of 1", samp_spans.size(), samp_spans[0]);
    else n_pass++;
    n_checks++; if (busy_spans[0] !== 38) $display("FAIL basic_busy: got %0d want 38", busy_spans[0]); else n_pass++;
    n_checks++; if (eoc_hi !== 2) $display("FAIL basic_eoc_width: got %0d want 2", eoc_hi); else n_pass++;
    n_checks++; if (adc_data !== 12'hA5C) $display("FAIL basic_data: got %h want a5c", adc_data); else n_pass++;
    n_checks++; if (dac_code !== 12'h000) $display("FAIL basic_idle_dac: got %h want 000", dac_code); else n_pass++;
    for (int i = 0; i < 12; i++)
      if (code_q[i] !== trial_code(vin, 11 - i) || len_q[i] !== 3) bad++;
    n_checks++;
    if (code_q.size() !== 12 || bad != 0)
      $display("FAIL basic_trials: got %0d runs (%0d bad) want 12 runs of 3 cycles", code_q.size(), bad);
    else n_pass++;
  endtask

  task automatic test_patterns();
    bit ok; int bad, samp, settle, tb_exp;
    logic [11:0] v, c;
    for (int it = 0; it < 6; it++) begin
      if (it == 0)      begin v = 12'h000; samp = 0; settle = 0; end
      else if (it == 1) begin v = 12'hFFF; samp = 0; settle = 0; end
      else begin
        v = 12'($urandom_range(0, 4095)); samp = $urandom_range(0, 3); settle = $urandom_range(0, 2);
      end
      c = {4'(settle), 4'(samp), 4'b0011};
      tb_exp = settle + 3;
      mon_clear(); vin = v;
      start_conv(c);
      wait_spans(1, 400, ok);
      step(3);
      bad = 0;
      for (int i = 0; i < 12; i++)
        if (code_q[i] !== trial_code(v, 11 - i) || len_q[i] !== tb_exp) bad++;
      n_checks++;
      if (!ok || adc_data !== v) $display("FAIL pat_data: vin %h got %h (done=%b)", v, adc_data, ok);
      else n_pass++;
      n_checks++;
      if (busy_spans[0] !== (samp + 1) + 12 * tb_exp + 1)
        $display("FAIL pat_busy: ctrl %h got %0d want %0d", c, busy_spans[0], (samp + 1) + 12 * tb_exp + 1);
      else n_pass++;
      n_checks++;
      if (samp_spans[0] !== samp + 1) $display("FAIL pat_sample: ctrl %h got %0d want %0d", c, samp_spans[0], samp + 1);
      else n_pass++;
      n_checks++;
      if (code_q[0] !== 12'h800 || code_q.size() !== 12 || bad != 0)
        $display("FAIL pat_trials: vin %h first %h runs %0d bad %0d want 800/12/0", v, code_q[0], code_q.size(), bad);
      else n_pass++;
    end
  endtask

  task automatic test_timing_snapshot();
    bit ok; int bad = 0;
    mon_clear(); vin = 12'h3C7;
    start_conv(12'h3F3);
    step(30);
    ctrl = 12'h003;                      // new timing + start while busy
    for (int k = 0; k < 200 && clr_n < 2; k++) step(1);
    ctrl = 12'h001;
    wait_spans(2, 200, ok);
    step(3);
    for (int i = 0; i < 12; i++)
      if (code_q[i] !== trial_code(vin, 11 - i) || len_q[i] !== 6) bad++;
    for (int i = 12; i < 24; i++)
      if (code_q[i] !== trial_code(vin, 23 - i) || len_q[i] !== 3) bad++;
    n_checks++; if (!ok || clr_n !== 2) $display("FAIL snap_pending_start: got %0d strobes want 2", clr_n); else n_pass++;
    n_checks++; if (samp_spans[0] !== 16) $display("FAIL snap_sample: got %0d want 16", samp_spans[0]); else n_pass++;
    n_checks++; if (busy_spans[0] !== 89) $display("FAIL snap_busy1: got %0d want 89", busy_spans[0]); else n_pass++;
    n_checks++; if (busy_spans[1] !== 38) $display("FAIL snap_busy2: got %0d want 38", busy_spans[1]); else n_pass++;
    n_checks++;
    if (code_q.size() !== 24 || bad != 0) $display("FAIL snap_trials: got %0d runs %0d bad want 24/0", code_q.size(), bad);
    else n_pass++;
    n_checks++;
    if (data_q.size() !== 2 || data_q[0] !== 12'h3C7 || data_q[1] !== 12'h3C7)
      $display("FAIL snap_data: got %0d results first %h want 2 x 3c7", data_q.size(), data_q[0]);
    else n_pass++;
  endtask

  task automatic test_continuous();
    bit ok; bit seen;
    logic [11:0] steps_v[3];
    steps_v[0] = 12'h123; steps_v[1] = 12'h456; steps_v[2] = 12'h789;
    mon_clear(); vin = steps_v[0];
    start_conv(12'h007);
    for (int lap = 0; lap < 3; lap++) begin
      seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin step(1); if (eoc) seen = 1; end
      n_checks++; if (!seen) $display("FAIL cont_eoc_timeout: lap %0d", lap); else n_pass++;
      if (lap < 2) vin = steps_v[lap + 1];
      else ctrl = 12'h001;               // leave continuous mode mid-lap
      step(2);
    end
    wait_spans(1, 200, ok);
    step(3);
    n_checks++;
    if (!ok || busy_spans.size() !== 1 || busy_spans[0] !== 152)
      $display("FAIL cont_busy: got %0d spans first %0d want 1 span of 152", busy_spans.size(), busy_spans[0]);
    else n_pass++;
    n_checks++;
    if (data_q.size() !== 4 || data_q[0] !== 12'h123 || data_q[1] !== 12'h456 ||
        data_q[2] !== 12'h789 || data_q[3] !== 12'h789)
      $display("FAIL cont_data: got %0d results %h %h %h %h want 123 456 789 789",
               data_q.size(), data_q[0], data_q[1], data_q[2], data_q[3]);
    else n_pass++;
    n_checks++; if (eoc_hi !== 8) $display("FAIL cont_eoc: got %0d high cycles want 8", eoc_hi); else n_pass++;
    n_checks++; if (clr_n !== 1) $display("FAIL cont_clr: got %0d want 1", clr_n); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok; bit found = 0;
    logic [11:0] va;
    va = 12'($urandom_range(0, 4095));
    mon_clear(); vin = va;
    start_conv(12'h003);
    wait_spans(1, 200, ok);
    step(3);
    mon_clear(); vin = ~va;
    start_conv(12'h003);
    for (int k = 0; k < 200 && !found; k++) begin
      if (busy && dac_code[6:0] == 7'h40) found = 1; else step(1);
    end
    ctrl = 12'h000;
    step(1);
    n_checks++; if (!found) $display("FAIL abort_trial6_timeout: trial 6 not reached"); else n_pass++;
    n_checks++;
    if ({busy, sample_en, dac_code} !== 14'h0)
      $display("FAIL abort_idle: got busy=%b se=%b dac=%h want 0 0 000", busy, sample_en, dac_code);
    else n_pass++;
    step(10);
    n_checks++;
    if (eoc_hi !== 0 || data_q.size() !== 0) $display("FAIL abort_no_eoc: got %0d eoc cycles want 0", eoc_hi);
    else n_pass++;
    n_checks++; if (adc_data !== va) $display("FAIL abort_data_kept: got %h want %h", adc_data, va); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; int bad = 0;
    logic [11:0] v;
    vin = 12'($urandom_range(1, 4095));
    start_conv(12'h003);
    step(10);
    n_checks++;
    if (busy !== 1'b1 || sample_en !== 1'b0) $display("FAIL rst_mid_state: got busy=%b se=%b want 1 0", busy, sample_en);
    else n_pass++;
    rst = 1;
    #1;
    n_checks++;
    if ({dac_code, adc_data, sample_en, busy, eoc, hw_clear} !== '0)
      $display("FAIL rst_mid_outputs: got dac=%h data=%h se=%b busy=%b eoc=%b clr=%b want all 0",
               dac_code, adc_data, sample_en, busy, eoc, hw_clear);
    else n_pass++;
    step(2);
    ctrl = 12'h000; rst = 0;
    step(2);
    v = 12'($urandom_range(0, 4095));
    mon_clear(); vin = v;
    start_conv(12'h003);
    wait_spans(1, 200, ok);
    step(3);
    for (int i = 0; i < 12; i++)
      if (code_q[i] !== trial_code(v, 11 - i) || len_q[i] !== 3) bad++;
    n_checks++;
    if (!ok || adc_data !== v || busy_spans[0] !== 38)
      $display("FAIL rst_recover: got data %h busy %0d want %h 38", adc_data, busy_spans[0], v);
    else n_pass++;
    n_checks++;
    if (code_q.size() !== 12 || bad != 0) $display("FAIL rst_recover_trials: got %0d runs %0d bad want 12/0", code_q.size(), bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_timing_snapshot();
    test_continuous();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
